// File: rtl/mp_ooo_sram_pkg.sv
// rtl/mp_ooo_sram_pkg.sv - shared constants and types for the data array SRAM controller
package mp_ooo_sram_pkg;

  localparam int SRAM_ADDR_WIDTH = 4;
  localparam int SRAM_DATA_WIDTH = 256;
  localparam int SRAM_NUM_WMASKS = SRAM_DATA_WIDTH / 8;

  typedef struct packed {
    logic                       we;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_NUM_WMASKS-1:0] wmask;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
  } sram_req_t;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_t;

endpackage

// File: rtl/mp_ooo_sram_resp_fifo.sv
// rtl/mp_ooo_sram_resp_fifo.sv - small synchronous response FIFO, cleared by rst
module mp_ooo_sram_resp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 256,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mp_ooo_data_array_ctrl.sv
// rtl/mp_ooo_data_array_ctrl.sv - request-to-macro controller with zero-fill init and credited read responses
module mp_ooo_data_array_ctrl
  import mp_ooo_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter int RESP_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  ctrl_state_t         state_q, state_d;
  logic [ADDR_WIDTH:0] init_cnt_q, init_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic                init_done_q, init_done_d;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       credits;
  logic                fifo_full, fifo_empty;

  // Credits come only from registered state, so resp_ready never reaches req_ready.
  assign credits    = CW'(RESP_DEPTH) - fifo_count - CW'(rd_pend_q);
  assign resp_valid = !fifo_empty;
  assign init_done  = init_done_q;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    rd_pend_d   = 1'b0;
    req_ready   = 1'b0;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (!rst) begin
      case (state_q)
        INIT: begin
          sram_csb0   = 1'b0;
          sram_web0   = 1'b0;
          sram_wmask0 = '1;
          sram_addr0  = init_cnt_q[ADDR_WIDTH-1:0];
          init_cnt_d  = init_cnt_q + 1'b1;
          if (init_cnt_d[ADDR_WIDTH]) begin
            state_d     = RUN;
            init_done_d = 1'b1;
          end
        end
        RUN: begin
          req_ready = req_we || (credits != '0);
          if (req_valid && req_ready) begin
            sram_csb0   = 1'b0;
            sram_web0   = !req_we;
            sram_addr0  = req_addr;
            sram_wmask0 = req_wmask;
            sram_din0   = req_wdata;
            rd_pend_d   = !req_we;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rd_pend_q   <= rd_pend_d;
      init_done_q <= init_done_d;
    end
  end

  mp_ooo_sram_resp_fifo #(
    .DEPTH(RESP_DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_pend_q),
    .push_data(sram_dout0),
    .pop      (resp_valid && resp_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head_data(resp_rdata)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(rd_pend_q && fifo_full));

endmodule

// File: tb/tb_mp_ooo_data_array_ctrl.sv
// tb/tb_mp_ooo_data_array_ctrl.sv - scoreboard bench for the data array controller
module tb_mp_ooo_data_array_ctrl;

  logic         clk;
  logic         rst;
  logic         req_valid, req_ready, req_we;
  logic [3:0]   req_addr;
  logic [31:0]  req_wmask;
  logic [255:0] req_wdata;
  logic         resp_valid, resp_ready;
  logic [255:0] resp_rdata;
  logic         init_done;
  logic         sram_csb0, sram_web0;
  logic [31:0]  sram_wmask0;
  logic [3:0]   sram_addr0;
  logic [255:0] sram_din0, sram_dout0;

  mp_ooo_data_array_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: one-cycle read latency, byte-masked writes, idle cycles replay the held write.
  logic [255:0] sram_mem [16];
  logic         held_v = 1'b0;
  logic [3:0]   held_addr;
  logic [31:0]  held_mask;
  logic [255:0] held_din;
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 32; b++)
          if (sram_wmask0[b]) sram_mem[sram_addr0][b*8 +: 8] = sram_din0[b*8 +: 8];
        held_v    = 1'b1;
        held_addr = sram_addr0;
        held_mask = sram_wmask0;
        held_din  = sram_din0;
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end else if (held_v) begin
      for (int b = 0; b < 32; b++)
        if (held_mask[b]) sram_mem[held_addr][b*8 +: 8] = held_din[b*8 +: 8];
    end
  end

  typedef struct {
    logic [255:0] data;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] ref_mem [16];
  int           vectors = 0;
  int           miscompares = 0;
  bit           lat_chk_en = 1'b0;
  bit           rand_rr = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  function automatic void model_accept(input bit we, input logic [3:0] a, input logic [31:0] m,
                                       input logic [255:0] d);
    if (we) begin
      for (int b = 0; b < 32; b++)
        if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      exp_q.push_back('{data: ref_mem[a], acc: cyc, lat: lat_chk_en});
    end
  endfunction

  task automatic do_req(input bit we, input logic [3:0] a, input logic [31:0] m, input logic [255:0] d,
                        input int max_cyc, input bit exp_acc);
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    for (int n = 0; n < max_cyc && !acc; n++) begin
      if (rand_rr) resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        model_accept(we, a, m, d);
      end
      step();
    end
    chk(we ? "write_accept" : "read_accept", 256'(acc), 256'(exp_acc));
    req_valid = 1'b0;
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) step();
    chk("drain_outstanding", 256'(exp_q.size()), 256'd0);
  endtask

  task automatic check_init();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("init_pins", {sram_csb0, sram_web0, sram_wmask0, sram_addr0, init_done, req_ready},
          {1'b0, 1'b0, 32'hFFFF_FFFF, 4'(i), 1'b0, 1'b0});
      chk("init_din", sram_din0, 256'd0);
      step();
    end
    @(negedge clk);
    chk("init_done_run", {init_done, sram_csb0}, {1'b1, 1'b1});
    step();
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Response monitor: latency check for flagged reads, data check on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() != 0 && exp_q[0].lat && cyc == exp_q[0].acc + 2)
        chk("resp_latency", 256'(resp_valid), 256'd1);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL resp_unexpected: got %h expected no response", resp_rdata);
        end else begin
          chk("resp_rdata", resp_rdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [255:0] d;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    step();
    @(negedge clk);
    chk("reset_pins", {sram_csb0, sram_web0, sram_wmask0, sram_addr0, req_ready, init_done, resp_valid},
        {1'b1, 1'b1, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0});
    chk("reset_din", sram_din0, 256'd0);
    step();
    rst = 1'b0;
    check_init();

    lat_chk_en = 1'b1;
    do_req(1'b0, 4'd5, '0, '0, 1, 1'b1);
    idle(3);

    do_req(1'b1, 4'd3, '1, {8{32'hDEADBEEF}}, 1, 1'b1);
    do_req(1'b0, 4'd3, '0, '0, 1, 1'b1);
    idle(3);

    do_req(1'b1, 4'd7, '1, {32{8'hAA}}, 1, 1'b1);
    d = rand256();
    d[7:0] = 8'h55;
    do_req(1'b1, 4'd7, 32'h1, d, 1, 1'b1);
    do_req(1'b0, 4'd7, '0, '0, 1, 1'b1);
    idle(3);
    drain();

    // Credit exhaustion with a stalled consumer; writes still flow.
    lat_chk_en = 1'b0;
    resp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) do_req(1'b0, 4'(i), '0, '0, 1, 1'b1);
    do_req(1'b0, 4'd4, '0, '0, 3, 1'b0);
    do_req(1'b1, 4'd9, '1, rand256(), 1, 1'b1);
    resp_ready = 1'b1;
    do_req(1'b0, 4'd4, '0, '0, 10, 1'b1);
    do_req(1'b0, 4'd5, '0, '0, 10, 1'b1);
    idle(2);
    drain();

    // Preload distinct data, then stream 16 back-to-back reads.
    for (int i = 0; i < 16; i++) do_req(1'b1, 4'(i), '1, rand256(), 1, 1'b1);
    lat_chk_en = 1'b1;
    for (int i = 0; i < 16; i++) do_req(1'b0, 4'(i), '0, '0, 1, 1'b1);
    idle(3);
    drain();

    lat_chk_en = 1'b0;
    rand_rr = 1'b1;
    repeat (150) begin
      do_req(1'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
             rand256(), 64, 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_rr = 1'b0;
    idle(1);
    drain();

    // Reset with two responses queued and one in flight.
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_req(1'b0, 4'(i + 8), '0, '0, 1, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    step();
    @(negedge clk);
    chk("mid_reset_state", {resp_valid, init_done, req_ready, sram_csb0}, {1'b0, 1'b0, 1'b0, 1'b1});
    step();
    rst = 1'b0;
    check_init();
    resp_ready = 1'b1;
    lat_chk_en = 1'b1;
    do_req(1'b0, 4'd0, '0, '0, 1, 1'b1);
    do_req(1'b0, 4'd9, '0, '0, 1, 1'b1);
    do_req(1'b0, 4'd15, '0, '0, 1, 1'b1);
    idle(3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
